// File: rtl/led_blink_pkg.sv
// ============================================================================
// Module  : led_blink_pkg
// Brief   : Shared types, widths and prescaler sizing helpers for led_blink_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package led_blink_pkg;

    localparam int MODE_W = 2;
    localparam int PWM_W  = 8;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF       = 2'd0,
        MODE_ON        = 2'd1,
        MODE_BLINK     = 2'd2,
        MODE_BLINK_INV = 2'd3
    } mode_e;

    function automatic int pre_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int pre_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_blink_ctrl_if.sv
// ============================================================================
// Module  : led_blink_ctrl_if
// Brief   : Host configuration bus of the LED blink controller.
//           cfg_duty exists only when LED_PWM_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_blink_ctrl_if
    import led_blink_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int PER_W = 16
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    mode_e            cfg_mode;
    logic [PER_W-1:0] cfg_half;
    logic             sync_pulse;
`ifdef LED_PWM_EN
    logic [PWM_W-1:0] cfg_duty;
`endif

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_half, sync_pulse
`ifdef LED_PWM_EN
      , output cfg_duty
`endif
    );

    modport slave (
        input cfg_we, cfg_ch, cfg_mode, cfg_half, sync_pulse
`ifdef LED_PWM_EN
      , input cfg_duty
`endif
    );

endinterface

`default_nettype wire

// File: rtl/led_blink_ch.sv
// ============================================================================
// Module  : led_blink_ch
// Brief   : One LED channel: mode/half-period registers, tick counter, phase
//           and registered LED drive. PWM duty gate present with LED_PWM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_blink_ch
    import led_blink_pkg::*;
#(
    parameter int PER_W    = 16,
    parameter int DEF_HALF = 500
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             we_i,
    input  wire logic             sync_i,
    input  wire logic             tick_i,
    input  wire mode_e            mode_i,
    input  wire logic [PER_W-1:0] half_i,
`ifdef LED_PWM_EN
    input  wire logic [PWM_W-1:0] duty_i,
    input  wire logic [PWM_W-1:0] pwm_cnt_i,
`endif
    output logic                  led_o
);

    mode_e            mode_q, mode_d;
    logic [PER_W-1:0] half_q, half_d;
    logic [PER_W-1:0] cnt_q,  cnt_d;
    logic             phase_q, phase_d;
    logic             led_q,   led_d;
    logic [PER_W-1:0] eff_half;
    logic             blinking;
    logic             base;
`ifdef LED_PWM_EN
    logic [PWM_W-1:0] duty_q, duty_d;
`endif

    assign eff_half = (half_q == '0) ? PER_W'(1) : half_q;
    assign blinking = (mode_q == MODE_BLINK) || (mode_q == MODE_BLINK_INV);

    always_comb begin
        mode_d  = mode_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        base    = 1'b0;
`ifdef LED_PWM_EN
        duty_d  = duty_q;
`endif
        // Write outranks sync, which outranks tick; a coinciding tick is dropped.
        if (we_i) begin
            mode_d  = mode_i;
            half_d  = half_i;
            cnt_d   = '0;
            phase_d = 1'b0;
`ifdef LED_PWM_EN
            duty_d  = duty_i;
`endif
        end else if (sync_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick_i && blinking) begin
            if (cnt_q == eff_half - PER_W'(1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + PER_W'(1);
            end
        end

        case (mode_q)
            MODE_ON:        base = 1'b1;
            MODE_BLINK:     base = phase_q;
            MODE_BLINK_INV: base = ~phase_q;
            default:        base = 1'b0;
        endcase

`ifdef LED_PWM_EN
        led_d = base & ((duty_q == '1) || (pwm_cnt_i < duty_q));
`else
        led_d = base;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= MODE_OFF;
            half_q  <= PER_W'(DEF_HALF);
            cnt_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= 1'b0;
`ifdef LED_PWM_EN
            duty_q  <= '1;
`endif
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
`ifdef LED_PWM_EN
            duty_q  <= duty_d;
`endif
        end
    end

    assign led_o = led_q;

endmodule

`default_nettype wire

// File: rtl/led_blink_ctrl.sv
// ============================================================================
// Module  : led_blink_ctrl
// Brief   : Multi-channel LED blink controller: shared tick prescaler, write
//           decode and N_CH channel instances. Define LED_PWM_EN for PWM dimming.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int N_CH     = 2,
    parameter int PER_W    = 16,
    parameter int DEF_HALF = 500
) (
    input  wire logic          CLOCK_50,
    input  wire logic          RST_N,
    led_blink_ctrl_if.slave    cfg_if,
    output logic               tick_o,
    output logic [N_CH-1:0]    LED
);

    localparam int PRE_DIV = pre_div(CLK_HZ, TICK_HZ);
    localparam int PRE_W   = pre_w(PRE_DIV);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;

    assign pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    // Registered so tick_o is high exactly while the count sits at PRE_DIV-1.
    assign tick_d = (pre_d == PRE_LAST);

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_q;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + PWM_W'(1);
        end
    end
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_blink_ch #(
            .PER_W    (PER_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk_i     (CLOCK_50),
            .rst_ni    (RST_N),
            .we_i      (cfg_if.cfg_we && (cfg_if.cfg_ch == CH_W'(i))),
            .sync_i    (cfg_if.sync_pulse),
            .tick_i    (tick_q),
            .mode_i    (cfg_if.cfg_mode),
            .half_i    (cfg_if.cfg_half),
`ifdef LED_PWM_EN
            .duty_i    (cfg_if.cfg_duty),
            .pwm_cnt_i (pwm_q),
`endif
            .led_o     (LED[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_led_blink_ctrl.sv
// ============================================================================
// Module  : tb_led_blink_ctrl
// Brief   : Randomised self-checking bench for led_blink_ctrl against a
//           tick-counting reference model (PRE_DIV=10, N_CH=2, DEF_HALF=3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_blink_ctrl;
    import led_blink_pkg::*;

    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 100;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int N_CH     = 2;
    localparam int PER_W    = 16;
    localparam int DEF_HALF = 3;

    logic            CLOCK_50;
    logic            RST_N;
    logic            tick_o;
    logic [N_CH-1:0] LED;

    led_blink_ctrl_if #(.N_CH(N_CH), .PER_W(PER_W)) cfg_if ();

    led_blink_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .N_CH     (N_CH),
        .PER_W    (PER_W),
        .DEF_HALF (DEF_HALF)
    ) u_dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .cfg_if   (cfg_if.slave),
        .tick_o   (tick_o),
        .LED      (LED)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: ticks elapsed since each channel's last restart.
    int              m_edges;
    int              m_mode [N_CH];
    int              m_half [N_CH];
    int              m_t    [N_CH];
    int              m_duty [N_CH];
    logic [N_CH-1:0] m_led;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic lit_base(input int mode, input int t, input int half);
        int eff;
        eff = (half == 0) ? 1 : half;
        case (mode)
            1:       return 1'b1;
            2:       return ((t / eff) % 2) == 1;
            3:       return ((t / eff) % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_edges = 0;
        m_led   = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_mode[i] = 0;
            m_half[i] = DEF_HALF;
            m_t[i]    = 0;
            m_duty[i] = 255;
        end
    endtask

    task automatic cycle();
        logic            tick;
        logic [N_CH-1:0] nl;
        int              pwm;
        @(posedge CLOCK_50);
        if (RST_N) begin
            tick = (m_edges % DIV) == DIV - 1;
            pwm  = m_edges % 256;
            m_edges++;
            for (int i = 0; i < N_CH; i++) begin
                nl[i] = lit_base(m_mode[i], m_t[i], m_half[i]);
`ifdef LED_PWM_EN
                nl[i] = nl[i] && (m_duty[i] == 255 || pwm < m_duty[i]);
`endif
                if (cfg_if.cfg_we && int'(cfg_if.cfg_ch) == i) begin
                    m_mode[i] = int'(cfg_if.cfg_mode);
                    m_half[i] = int'(cfg_if.cfg_half);
                    m_t[i]    = 0;
`ifdef LED_PWM_EN
                    m_duty[i] = int'(cfg_if.cfg_duty);
`endif
                end else if (cfg_if.sync_pulse) begin
                    m_t[i] = 0;
                end else if (tick && m_mode[i] >= 2) begin
                    m_t[i]++;
                end
            end
            m_led = nl;
        end
        @(negedge CLOCK_50);
        chk("led", 32'(LED), 32'(m_led));
        chk("tick", 32'(tick_o), 32'(RST_N && ((m_edges % DIV) == DIV - 1)));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_write(input int ch, input int mode, input int half, input int duty);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_ch   = ch[0];
        cfg_if.cfg_mode = mode_e'(mode[1:0]);
        cfg_if.cfg_half = half[PER_W-1:0];
`ifdef LED_PWM_EN
        cfg_if.cfg_duty = duty[7:0];
`else
        if (duty < 0) $display("negative duty ignored");
`endif
        cycle();
        cfg_if.cfg_we = 1'b0;
    endtask

    task automatic do_sync();
        cfg_if.sync_pulse = 1'b1;
        cycle();
        cfg_if.sync_pulse = 1'b0;
    endtask

    initial begin
        int lit_cnt;
        cfg_if.cfg_we     = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_mode   = MODE_OFF;
        cfg_if.cfg_half   = '0;
        cfg_if.sync_pulse = 1'b0;
`ifdef LED_PWM_EN
        cfg_if.cfg_duty   = 8'hFF;
`endif
        RST_N = 1'b1;
        model_reset();
        #2 RST_N = 1'b0;
        run(5);
        chk("rst_led", 32'(LED), 32'h0);
        chk("rst_tick", 32'(tick_o), 32'h0);
        RST_N = 1'b1;
        run(25);

        do_write(0, 2, 3, 255);
        run(310);

        do_write(1, 3, 3, 255);
        do_sync();
        cycle();
        for (int k = 0; k < 150; k++) begin
            cycle();
            chk("excl", 32'(LED[0] ^ LED[1]), 32'h1);
        end

        do_write(0, 2, 0, 255);
        run(60);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0)
                do_write($urandom_range(0, 1), $urandom_range(0, 3),
                         $urandom_range(0, 4), $urandom_range(0, 255));
            else if ($urandom_range(0, 39) == 0)
                do_sync();
            else
                cycle();
        end

        do_write(0, 2, 2, 255);
        for (int k = 0; k < 200 && !LED[0]; k++) cycle();
        chk("wait_lit", 32'(LED[0]), 32'h1);
        #2 RST_N = 1'b0;
        model_reset();
        #1 chk("async_rst", 32'(LED), 32'h0);
        run(3);
        RST_N = 1'b1;
        run(50);

`ifdef LED_PWM_EN
        do_write(0, 1, 3, 8'h40);
        lit_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            cycle();
            if (LED[0]) lit_cnt++;
        end
        chk("pwm_40", 32'(lit_cnt), 32'd64);
        do_write(0, 1, 3, 8'h00);
        lit_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            cycle();
            if (LED[0]) lit_cnt++;
        end
        chk("pwm_00", 32'(lit_cnt), 32'd0);
`else
        lit_cnt = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
